// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus: payload widths, requester
// indices, the "no dependency" tag and the rotation helper used by the picker.
package cdb_arbiter_pkg;

    localparam int Data_Width     = 32;
    localparam int Tag_Width      = 4;
    localparam int Reg_Addr_Width = 5;

    localparam int CDB_ALU = 0;
    localparam int CDB_LSB = 1;
    localparam int CDB_BR  = 2;

    localparam logic [Tag_Width-1:0] TAG_NONE = 4'd0;

    // Candidate index k positions after the last grant, wrapping over n requesters.
    function automatic int rr_index(input int last, input int k, input int n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Rotating priority encoder: the first valid requester after `last`
// (wrapping) wins. Purely combinational.
module rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic             found_s;
    logic             hit_s;
    logic [IDX_W-1:0] cand_s;

    // Walk the rotated order once; the first hit latches the grant.
    always_comb begin
        grant_o     = {N_REQ{1'b0}};
        grant_idx_o = {IDX_W{1'b0}};
        found_s     = 1'b0;
        hit_s       = 1'b0;
        cand_s      = {IDX_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s          = IDX_W'(rr_index(int'(last_i), k, N_REQ));
            hit_s           = !found_s && req_valid_i[cand_s];
            grant_o[cand_s] = grant_o[cand_s] | hit_s;
            grant_idx_o     = hit_s ? cand_s : grant_idx_o;
            found_s         = found_s | hit_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one producer per cycle
// and drives a registered broadcast of its result to the rest of the core.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int  N_REQ  = 3,
    parameter int  DATA_W = Data_Width,
    parameter int  TAG_W  = Tag_Width,
    parameter int  ADDR_W = Reg_Addr_Width,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_value,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [DATA_W-1:0]       cdb_value,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [ADDR_W-1:0]       cdb_addr,
    output logic [SRC_W-1:0]        cdb_src
);

    localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(N_REQ - 1);

    logic [N_REQ-1:0]  pick_grant_s;
    logic [SRC_W-1:0]  pick_idx_s;
    logic              grant_en_s;
    logic              has_grant_s;
    logic [DATA_W-1:0] win_value_s;
    logic [TAG_W-1:0]  win_tag_s;
    logic [ADDR_W-1:0] win_addr_s;

    logic [SRC_W-1:0]  last_q,  last_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [SRC_W-1:0]  src_q,   src_d;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (SRC_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .last_i      (last_q),
        .grant_o     (pick_grant_s),
        .grant_idx_o (pick_idx_s)
    );

    // Reset is part of the gate so nothing retires while the core is held in reset.
    assign grant_en_s  = rst & rdy & ~flush;
    assign req_ready   = grant_en_s ? pick_grant_s : {N_REQ{1'b0}};
    assign has_grant_s = |req_ready;

    assign win_value_s = req_value[pick_idx_s*DATA_W +: DATA_W];
    assign win_tag_s   = req_tag[pick_idx_s*TAG_W +: TAG_W];
    assign win_addr_s  = req_addr[pick_idx_s*ADDR_W +: ADDR_W];

    // Next-state: flush beats pause; a tag-0 winner retires without broadcasting.
    always_comb begin
        last_d  = last_q;
        valid_d = valid_q;
        value_d = value_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        src_d   = src_q;
        if (flush) begin
            valid_d = 1'b0;
            last_d  = LAST_RST;
        end else if (!rdy) begin
            valid_d = valid_q;
        end else if (has_grant_s) begin
            last_d = pick_idx_s;
            if (win_tag_s != TAG_W'(TAG_NONE)) begin
                valid_d = 1'b1;
                value_d = win_value_s;
                tag_d   = win_tag_s;
                addr_d  = win_addr_s;
                src_d   = pick_idx_s;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and broadcast registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= LAST_RST;
            valid_q <= 1'b0;
            value_q <= {DATA_W{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            src_q   <= {SRC_W{1'b0}};
        end else begin
            last_q  <= last_d;
            valid_q <= valid_d;
            value_q <= value_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_value = value_q;
    assign cdb_tag   = tag_q;
    assign cdb_addr  = addr_q;
    assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the arbitration rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int AW = 5;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    logic flush = 1'b0;

    logic [N-1:0]    pv;
    logic [DW-1:0]   pval  [N];
    logic [TW-1:0]   ptag  [N];
    logic [AW-1:0]   paddr [N];

    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_value;
    logic [N*TW-1:0] req_tag;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_value;
    logic [TW-1:0]   cdb_tag;
    logic [AW-1:0]   cdb_addr;
    logic [SW-1:0]   cdb_src;

    int checks = 0;
    int errors = 0;

    int            m_last;
    logic          m_valid;
    logic [DW-1:0] m_value;
    logic [TW-1:0] m_tag;
    logic [AW-1:0] m_addr;
    int            m_src;
    logic [N-1:0]  acc;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_tag   (req_tag),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_value (cdb_value),
        .cdb_tag   (cdb_tag),
        .cdb_addr  (cdb_addr),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = pv;
        req_value = '0;
        req_tag   = '0;
        req_addr  = '0;
        for (int i = 0; i < N; i++) begin
            req_value[i*DW +: DW] = pval[i];
            req_tag[i*TW +: TW]   = ptag[i];
            req_addr[i*AW +: AW]  = paddr[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_valid = 1'b0;
        m_value = '0;
        m_tag   = '0;
        m_addr  = '0;
        m_src   = 0;
    endtask

    task automatic check_outputs(input string name);
        chk({name, ".valid"}, 64'(cdb_valid), 64'(m_valid));
        chk({name, ".value"}, 64'(cdb_value), 64'(m_value));
        chk({name, ".tag"},   64'(cdb_tag),   64'(m_tag));
        chk({name, ".addr"},  64'(cdb_addr),  64'(m_addr));
        chk({name, ".src"},   64'(cdb_src),   64'(m_src));
    endtask

    // Entered at posedge+1 or +2; leaves at posedge+1 with the model advanced.
    task automatic cycle(input string name);
        logic [N-1:0] e;
        int gi;
        #2;
        e = (rst && rdy && !flush) ? pick(m_last, pv) : '0;
        chk({name, ".ready"}, 64'(req_ready), 64'(e));
        acc = e;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_last  = N - 1;
        end else if (rdy) begin
            if (e != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (e[i]) gi = i;
                m_last = gi;
                if (ptag[gi] != 4'd0) begin
                    m_valid = 1'b1;
                    m_value = pval[gi];
                    m_tag   = ptag[gi];
                    m_addr  = paddr[gi];
                    m_src   = gi;
                end else begin
                    m_valid = 1'b0;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_outputs(name);
    endtask

    task automatic retire();
        for (int i = 0; i < N; i++) if (acc[i]) pv[i] = 1'b0;
    endtask

    task automatic new_req(input int i, input logic [TW-1:0] tag);
        pv[i]    = 1'b1;
        pval[i]  = $urandom;
        ptag[i]  = tag;
        paddr[i] = AW'($urandom_range(0, 31));
    endtask

    initial begin
        pv = '0;
        for (int i = 0; i < N; i++) begin
            pval[i] = '0; ptag[i] = '0; paddr[i] = '0;
        end
        model_reset();
        acc = '0;

        // Reset state: no accept even with a request and rdy high
        rdy = 1'b1;
        pv[0] = 1'b1; ptag[0] = 4'd1;
        #12;
        chk("rst.ready", 64'(req_ready), 64'(0));
        check_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        pv = '0;
        @(posedge clk); #1;

        // Single ALU request
        pv[0] = 1'b1; pval[0] = 32'h1234; ptag[0] = 4'd3; paddr[0] = 5'd5;
        #1;
        chk("single.ready_const", 64'(req_ready), 64'(3'b001));
        cycle("single");
        chk("single.value_const", 64'(cdb_value), 64'(32'h1234));
        chk("single.valid_const", 64'(cdb_valid), 64'(1));
        chk("single.src_const", 64'(cdb_src), 64'(0));
        retire();

        // Flush with nothing pending puts the pointer back to N-1
        flush = 1'b1;
        cycle("flush0");
        flush = 1'b0;

        // Fairness: all three continuously valid
        for (int i = 0; i < N; i++) new_req(i, TW'($urandom_range(1, 15)));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fair.ready_const", 64'(req_ready), 64'(N'(1) << (k % N)));
            cycle("fair");
            chk("fair.valid_const", 64'(cdb_valid), 64'(1));
            retire();
            for (int i = 0; i < N; i++) if (!pv[i]) new_req(i, TW'($urandom_range(1, 15)));
        end

        // Pause mid-stream
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) cycle("pause");
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("resume");
            retire();
            for (int i = 0; i < N; i++) if (!pv[i]) new_req(i, TW'($urandom_range(1, 15)));
        end

        // Flush with LSB and branch valid, last = 0
        pv = '0;
        new_req(0, 4'd2);
        flush = 1'b1; cycle("pre_flush"); flush = 1'b0;
        cycle("last0");
        retire();
        new_req(1, 4'd4);
        new_req(2, 4'd6);
        flush = 1'b1;
        cycle("flush");
        chk("flush.valid_const", 64'(cdb_valid), 64'(0));
        flush = 1'b0;
        #1;
        chk("after_flush.ready_const", 64'(req_ready), 64'(3'b010));
        cycle("after_flush");
        retire();
        pv = '0;

        // Tag-0 request from the branch unit
        new_req(2, 4'd0);
        #1;
        chk("tag0.ready_const", 64'(req_ready), 64'(3'b100));
        cycle("tag0");
        chk("tag0.valid_const", 64'(cdb_valid), 64'(0));
        retire();
        new_req(0, 4'd7);
        cycle("post_tag0");
        chk("post_tag0.valid_const", 64'(cdb_valid), 64'(1));
        retire();

        // Async reset during a broadcast
        new_req(1, 4'd9);
        cycle("pre_areset");
        retire();
        new_req(0, 4'd11);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("areset.valid_const", 64'(cdb_valid), 64'(0));
        chk("areset.ready", 64'(req_ready), 64'(0));
        check_outputs("areset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        cycle("after_areset");
        chk("after_areset.src_const", 64'(cdb_src), 64'(0));
        retire();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(0, 1) == 1) new_req(i, TW'($urandom_range(0, 15)));
            rdy   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle("rand");
            retire();
            if (flush) pv = '0;
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
